// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb -- round-robin ROM request arbiter for SLOTS game-side
// clients sharing the single SDRAM read port of the frame.
//
// Each slot keeps a one-word cache (address, data, valid). A slot hits when
// its cs is high, the cache is valid and the address matches. A slot that
// misses is pending. One pending slot is served at a time, in round-robin
// order starting at rr_ptr.
//
// Optional feature: JTFRAME_ROM_CACHE_EN
//   defined   - cached words persist, so a repeat read of the same address
//               hits without an SDRAM access.
//   undefined - the valid bit drops on the falling edge of the slot's cs, so
//               every new cs assertion triggers a fresh fetch.
//
// Ports:
//   clk_rom, rst_n          clock / asynchronous active-low reset
//   downloading             ROM download: blocks requests, invalidates caches
//   slot_cs[SLOTS]          per-slot level-held read request
//   slot_addr[SLOTS*AW]     slot i at [i*AW +: AW]
//   slot_ok[SLOTS]          data valid for the current slot address
//   slot_dout[SLOTS*DW]     slot i at [i*DW +: DW]
//   sdram_req, sdram_addr   request to the SDRAM controller
//   sdram_ack               one-cycle pulse: request accepted
//   data_read, data_rdy     read data and its one-cycle valid pulse
//   refresh_en              arbiter idle with nothing pending

module jtframe_rom_arb_slot #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          ok,
    output logic [DW-1:0] dout
);
    logic [AW-1:0] ca;
    logic          v;
`ifndef JTFRAME_ROM_CACHE_EN
    logic          cs_d;
`endif

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            ca   <= '0;
            dout <= '0;
            v    <= 1'b0;
`ifndef JTFRAME_ROM_CACHE_EN
            cs_d <= 1'b0;
`endif
        end else begin
            if (we) begin
                ca   <= waddr;
                dout <= wdata;
                // data fetched during a download is stale: keep it invalid
                v    <= ~downloading;
            end
            if (downloading) v <= 1'b0;
`ifndef JTFRAME_ROM_CACHE_EN
            cs_d <= cs;
            // a released cs forgets the word, even one stored this cycle
            if (cs_d && !cs) v <= 1'b0;
`endif
        end
    end

    // combinational so an address change drops ok in the same cycle
    assign ok = cs & v & (addr == ca);
endmodule

module jtframe_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic               clk_rom,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic [SLOTS-1:0]   slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]   slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic               sdram_req,
    output logic [AW-1:0]      sdram_addr,
    input  logic               sdram_ack,
    input  logic [DW-1:0]      data_read,
    input  logic               data_rdy,
    output logic               refresh_en
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     rr_ptr, rr_nxt, sel, sel_nxt, pick;
    logic              req_nxt, found, store;
    logic [AW-1:0]     addr_nxt;
    logic [SLOTS-1:0]  pending;

    assign pending    = slot_cs & ~slot_ok & {SLOTS{~downloading}};
    assign refresh_en = (state == IDLE) & ~|pending;

    // first pending slot at or after rr_ptr, wrapping modulo SLOTS
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < SLOTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= SLOTS) j = j - SLOTS;
            if (!found && pending[j]) begin
                found = 1'b1;
                pick  = SW'(j);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = sdram_req;
        addr_nxt  = sdram_addr;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        store     = 1'b0;
        case (state)
            IDLE: if (found) begin
                sel_nxt   = pick;
                addr_nxt  = slot_addr[int'(pick)*AW +: AW];
                req_nxt   = 1'b1;
                rr_nxt    = (int'(pick) == SLOTS-1) ? '0 : pick + 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: if (sdram_ack) begin
                req_nxt = 1'b0;
                // ack and rdy together: take them in order within one cycle
                if (data_rdy) begin
                    store     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: if (data_rdy) begin
                store     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            sel        <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            sel        <= sel_nxt;
            sdram_req  <= req_nxt;
            sdram_addr <= addr_nxt;
        end
    end

    // sdram_addr doubles as the latched request address for the store
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        jtframe_rom_arb_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk_rom     (clk_rom),
            .rst_n       (rst_n),
            .downloading (downloading),
            .cs          (slot_cs[i]),
            .addr        (slot_addr[i*AW +: AW]),
            .we          (store && (int'(sel) == i)),
            .waddr       (sdram_addr),
            .wdata       (data_read),
            .ok          (slot_ok[i]),
            .dout        (slot_dout[i*DW +: DW])
        );
    end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
module tb_jtframe_rom_arb;
    localparam int SLOTS = 4, AW = 22, DW = 32;

    logic                clk_rom = 1'b0;
    logic                rst_n = 1'b0;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                data_rdy = 1'b0;
    logic                refresh_en;

    int checks = 0, passed = 0;

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(slot_ok),
        .slot_dout(slot_dout), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_read(data_read), .data_rdy(data_rdy),
        .refresh_en(refresh_en)
    );

    always #5 clk_rom = ~clk_rom;

    typedef struct {
        int          slot;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;     // also the expected slot_dout
        int          ack_dly;
        int          rdy_dly;  // 0: rdy in the same cycle as ack
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk_rom); #1;
    endtask

    task automatic set_slot(input int s, input logic [AW-1:0] a, input logic cs);
        slot_addr[s*AW +: AW] = a;
        slot_cs[s] = cs;
    endtask

    task automatic wait_req(input logic [AW-1:0] a, input string nm);
        int n = 0;
        while (sdram_req !== 1'b1 && n < 40) begin step(); n++; end
        chk({nm, " req"}, 64'(sdram_req), 64'd1);
        chk({nm, " addr"}, 64'(sdram_addr), 64'(a));
    endtask

    task automatic ack(input int dly, input bit with_rdy, input logic [DW-1:0] d);
        for (int i = 1; i < dly; i++) step();
        sdram_ack = 1'b1;
        if (with_rdy) begin data_rdy = 1'b1; data_read = d; end
        step();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
    endtask

    task automatic rdy(input int dly, input logic [DW-1:0] d);
        for (int i = 1; i < dly; i++) step();
        data_rdy = 1'b1; data_read = d;
        step();
        data_rdy = 1'b0;
    endtask

    // full SDRAM transaction; returns one cycle after the rdy sample (+2ns)
    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ad, input int rd, input string nm);
        wait_req(a, nm);
        ack(ad, rd == 0, d);
        chk({nm, " req drop"}, 64'(sdram_req), 64'd0);
        if (rd > 0) rdy(rd, d);
        #1;
    endtask

    task automatic watch_no_req(input int n, input string nm);
        bit saw = 1'b0;
        for (int i = 0; i < n; i++) begin step(); if (sdram_req) saw = 1'b1; end
        chk(nm, 64'(saw), 64'd0);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{0, 22'h001234, 32'hDEADBEEF, 3, 4};
        tbl[1] = '{1, 22'h000001, 32'h01234567, 1, 1};
        tbl[2] = '{2, 22'h2AAAAA, 32'hA5A55A5A, 2, 0};
        tbl[3] = '{3, 22'h3FFFFF, 32'hFFFFFFFF, 1, 3};

        // reset state
        step(); step();
        chk("rst req", 64'(sdram_req), 64'd0);
        chk("rst addr", 64'(sdram_addr), 64'd0);
        chk("rst dout", 64'(|slot_dout), 64'd0);
        rst_n = 1'b1;
        step(); step();
        chk("idle req", 64'(sdram_req), 64'd0);
        chk("idle ok", 64'(slot_ok), 64'd0);
        chk("idle refresh_en", 64'(refresh_en), 64'd1);

        // single-slot misses with varied handshake timing
        for (int t = 0; t < 4; t++) begin
            set_slot(tbl[t].slot, tbl[t].addr, 1'b1);
            #1 chk($sformatf("v%0d refresh_en busy", t), 64'(refresh_en), 64'd0);
            step();
            chk($sformatf("v%0d req latency", t), 64'(sdram_req), 64'd1);
            fetch(tbl[t].addr, tbl[t].data, tbl[t].ack_dly, tbl[t].rdy_dly, $sformatf("v%0d", t));
            chk($sformatf("v%0d ok", t), 64'(slot_ok[tbl[t].slot]), 64'd1);
            chk($sformatf("v%0d dout", t), 64'(slot_dout[tbl[t].slot*DW +: DW]), 64'(tbl[t].data));
            slot_cs = '0;
            step(); step();
        end

        // round robin from rr_ptr=0
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        set_slot(0, 22'h100, 1); set_slot(1, 22'h101, 1); set_slot(3, 22'h103, 1);
        fetch(22'h100, 32'h100, 1, 1, "rr1 s0");
        fetch(22'h101, 32'h101, 1, 1, "rr1 s1");
        fetch(22'h103, 32'h103, 1, 1, "rr1 s3");
        chk("rr1 ok", 64'(slot_ok), 64'b1011);
        slot_cs = '0; step();
        set_slot(0, 22'h200, 1); set_slot(1, 22'h201, 1); set_slot(3, 22'h203, 1);
        fetch(22'h200, 32'h200, 1, 1, "rr2 s0");
        fetch(22'h201, 32'h201, 1, 1, "rr2 s1");
        fetch(22'h203, 32'h203, 1, 1, "rr2 s3");
        slot_cs = '0; step();
        set_slot(1, 22'h301, 1);
        fetch(22'h301, 32'h301, 1, 1, "rr3 s1");
        slot_cs = '0; step();
        // rr_ptr now 2: order 3,0,1
        set_slot(0, 22'h400, 1); set_slot(1, 22'h401, 1); set_slot(3, 22'h403, 1);
        fetch(22'h403, 32'h403, 1, 1, "rr4 s3");
        fetch(22'h400, 32'h400, 1, 1, "rr4 s0");
        fetch(22'h401, 32'h401, 1, 1, "rr4 s1");
        chk("rr4 dout1", 64'(slot_dout[1*DW +: DW]), 64'h401);
        slot_cs = '0; step(); step();

        // reread after a cs toggle
        set_slot(2, 22'h2A, 1);
        fetch(22'h2A, 32'hCAFE0001, 1, 2, "c1");
        chk("c1 ok", 64'(slot_ok[2]), 64'd1);
        slot_cs[2] = 1'b0; step(); step();
        slot_cs[2] = 1'b1; #1;
`ifdef JTFRAME_ROM_CACHE_EN
        chk("cache hit ok", 64'(slot_ok[2]), 64'd1);
        watch_no_req(5, "cache hit no req");
`else
        chk("nocache ok", 64'(slot_ok[2]), 64'd0);
        fetch(22'h2A, 32'hCAFE0002, 1, 1, "nocache refetch");
        chk("nocache dout", 64'(slot_dout[2*DW +: DW]), 64'hCAFE0002);
`endif
        slot_cs = '0; step(); step();

        // address change during WAIT_RDY
        set_slot(1, 22'h10, 1);
        wait_req(22'h10, "ac");
        ack(2, 1'b0, '0);
        set_slot(1, 22'h20, 1);
        rdy(2, 32'h11111111); #1;
        chk("ac stale ok", 64'(slot_ok[1]), 64'd0);
        fetch(22'h20, 32'h22222222, 1, 1, "ac refetch");
        chk("ac ok", 64'(slot_ok[1]), 64'd1);
        chk("ac dout", 64'(slot_dout[1*DW +: DW]), 64'h22222222);
        slot_cs = '0; step(); step();

        // download during WAIT_ACK
        set_slot(0, 22'h55, 1);
        wait_req(22'h55, "dl");
        downloading = 1'b1;
        ack(3, 1'b0, '0);
        rdy(2, 32'hD0D0D0D0); #1;
        chk("dl ok", 64'(slot_ok[0]), 64'd0);
        watch_no_req(6, "dl no req");
        chk("dl refresh_en", 64'(refresh_en), 64'd1);
        downloading = 1'b0;
        fetch(22'h55, 32'h55AA55AA, 2, 2, "dl refetch");
        chk("dl refetch ok", 64'(slot_ok[0]), 64'd1);
        chk("dl refetch dout", 64'(slot_dout[0 +: DW]), 64'h55AA55AA);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
